// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: handshake state
// encoding plus the ID->EXE default widths and field offsets.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    // ID->EXE control vector: {S, B, MEM_W, MEM_R, WB_EN, EXE_CMD[3:0]}
    localparam int unsigned CTRL_EXE_CMD_LSB = 0;
    localparam int unsigned CTRL_EXE_CMD_W   = 4;
    localparam int unsigned CTRL_WB_EN       = 4;
    localparam int unsigned CTRL_MEM_R       = 5;
    localparam int unsigned CTRL_MEM_W       = 6;
    localparam int unsigned CTRL_B           = 7;
    localparam int unsigned CTRL_S           = 8;
    localparam int unsigned ID_EXE_CTRL_W    = 9;

    // ID->EXE payload layout, LSB offsets; bits [149:145] are reserved.
    localparam int unsigned DATA_PC_LSB      = 0;
    localparam int unsigned DATA_PC_W        = 32;
    localparam int unsigned DATA_VAL_RN_LSB  = 32;
    localparam int unsigned DATA_VAL_RN_W    = 32;
    localparam int unsigned DATA_VAL_RM_LSB  = 64;
    localparam int unsigned DATA_VAL_RM_W    = 32;
    localparam int unsigned DATA_IMM24_LSB   = 96;
    localparam int unsigned DATA_IMM24_W     = 24;
    localparam int unsigned DATA_SHIFT_LSB   = 120;
    localparam int unsigned DATA_SHIFT_W     = 12;
    localparam int unsigned DATA_DEST_LSB    = 132;
    localparam int unsigned DATA_DEST_W      = 4;
    localparam int unsigned DATA_SRC1_LSB    = 136;
    localparam int unsigned DATA_SRC1_W      = 4;
    localparam int unsigned DATA_SRC2_LSB    = 140;
    localparam int unsigned DATA_SRC2_W      = 4;
    localparam int unsigned DATA_CARRY       = 144;
    localparam int unsigned ID_EXE_DATA_W    = 150;

endpackage

// File: rtl/pipe_stage_skid_reg.sv
// Valid/ready pipeline register with a one-entry skid buffer, flush-to-bubble
// and a saturating downstream-stall counter.
module pipe_stage_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W      = ID_EXE_CTRL_W,
    parameter int unsigned DATA_W      = ID_EXE_DATA_W,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [DATA_W-1:0]      out_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    state_t state, state_next;

    logic in_fire, out_fire;
    logic load_main_in, load_main_skid, load_skid;

    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;

    // Both handshake outputs come from registered state only.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_next   = BUSY;
                    load_main_in = 1'b1;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    state_next = FULL;
                    load_skid  = 1'b1;
                end else if (out_fire) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_next     = BUSY;
                    load_main_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
        if (flush) begin
            state_next     = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            main_ctrl <= '0;
            skid_ctrl <= '0;
        end else if (flush) begin
            main_ctrl <= '0;
            skid_ctrl <= '0;
        end else begin
            if (load_main_in) begin
                main_ctrl <= in_ctrl;
            end else if (load_main_skid) begin
                main_ctrl <= skid_ctrl;
            end
            if (load_skid) begin
                skid_ctrl <= in_ctrl;
            end
        end
    end

    // Payload carries no reset; it is only meaningful alongside out_valid.
    always_ff @(posedge clk) begin
        if (load_main_in) begin
            main_data <= in_data;
        end else if (load_main_skid) begin
            main_data <= skid_data;
        end
        if (load_skid) begin
            skid_data <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Stale ctrl may remain after a normal drain, so gate it to a bubble.
    assign out_ctrl = out_valid ? main_ctrl : '0;
    assign out_data = main_data;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboard bench for pipe_stage_skid_reg: directed stimulus pushes expected
// entries, a negedge monitor pops them on every output handshake.
module tb_pipe_stage_skid_reg;

    localparam int unsigned CW = 9;
    localparam int unsigned DW = 150;
    localparam int unsigned SW = 4;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [SW-1:0] stall_cnt;

    int     tests = 0;
    int     fails = 0;
    entry_t sb[$];

    pipe_stage_skid_reg #(
        .CTRL_W(CW),
        .DATA_W(DW),
        .STALL_CNT_W(SW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_ctrl(in_ctrl),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl(out_ctrl),
        .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got ctrl 0x%0h data 0x%0h, expected nothing", out_ctrl, out_data);
                end else begin
                    entry_t e;
                    e = sb.pop_front();
                    check("sb_ctrl", DW'(out_ctrl), DW'(e.c));
                    check("sb_data", out_data, e.d);
                end
            end else if (!out_valid) begin
                check("bubble_ctrl", DW'(out_ctrl), '0);
            end
        end
    end

    // One cycle of stimulus; inputs change 1 time unit after the rising edge.
    task automatic cyc(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic ordy, input logic fl, input logic exp_rdy, input logic keep);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        check("in_ready", DW'(in_ready), DW'(exp_rdy));
        if (v && exp_rdy && keep) begin
            entry_t e;
            e.c = c;
            e.d = d;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 9'h1FF;
        in_data   = 150'h55;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", DW'(out_valid), '0);
        check("rst_in_ready", DW'(in_ready), DW'(1));
        check("rst_out_ctrl", DW'(out_ctrl), '0);
        check("rst_stall_cnt", DW'(stall_cnt), '0);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;

        // Streaming: each value appears one cycle after acceptance, no gaps.
        for (int i = 1; i <= 8; i++) begin
            in_valid  = 1'b1;
            in_ctrl   = 9'h1A5;
            in_data   = DW'(i);
            out_ready = 1'b1;
            @(negedge clk);
            check("stream_in_ready", DW'(in_ready), DW'(1));
            if (i > 1) begin
                check("stream_out_valid", DW'(out_valid), DW'(1));
                check("stream_out_data", out_data, DW'(i - 1));
            end
            sb.push_back('{c: 9'h1A5, d: DW'(i)});
            @(posedge clk);
            #1;
        end
        cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("stream_drained", DW'(out_valid), '0);
        @(posedge clk);
        #1;

        // Backpressure: 2 lands in the skid, 3 waits upstream.
        cyc(1'b1, 9'h0C3, DW'(1), 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 9'h0C3, DW'(2), 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 9'h0C3, DW'(3), 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 9'h0C3, DW'(3), 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 9'h0C3, DW'(3), 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 9'h0C3, DW'(3), 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("bp_stall_cnt", DW'(stall_cnt), DW'(3));
        check("bp_drained", DW'(out_valid), '0);
        check("bp_sb_empty", DW'(sb.size()), '0);
        @(posedge clk);
        #1;

        // Flush while FULL with a concurrent input offer.
        cyc(1'b1, 9'h111, 150'hA1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 9'h122, 150'hA2, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 9'h133, 150'hA3, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("flush_out_valid", DW'(out_valid), '0);
        check("flush_out_ctrl", DW'(out_ctrl), '0);
        check("flush_in_ready", DW'(in_ready), DW'(1));
        check("flush_stall_cnt", DW'(stall_cnt), DW'(5));
        @(posedge clk);
        #1;
        repeat (3) cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Saturation, then a flush must not clear the counter.
        cyc(1'b1, 9'h1F0, 150'hB1, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (20) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("sat_stall_cnt", DW'(stall_cnt), DW'(15));
        cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("sat_after_flush", DW'(stall_cnt), DW'(15));
        check("sat_flush_valid", DW'(out_valid), '0);

        // Reset mid-stream while FULL, with flush also asserted.
        cyc(1'b1, 9'h0AA, 150'hC1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 9'h0BB, 150'hC2, 1'b0, 1'b0, 1'b1, 1'b0);
        check("full_in_ready", DW'(in_ready), '0);
        rst = 1'b0;
        cyc(1'b1, 9'h0CC, 150'hC3, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("mid_rst_out_valid", DW'(out_valid), '0);
        check("mid_rst_in_ready", DW'(in_ready), DW'(1));
        check("mid_rst_out_ctrl", DW'(out_ctrl), '0);
        check("mid_rst_stall_cnt", DW'(stall_cnt), '0);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        repeat (2) cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("final_sb_empty", DW'(sb.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid_reg.md
# pipe_stage_skid_reg

Parametrised inter-stage pipeline register for the ARM core, the successor to the fixed-field ID→EXE latch. It carries a generic control vector and data payload between any two stages using a valid/ready handshake, with a one-entry skid buffer so backpressure never drops a transfer. A flush squashes every held entry into a zero-control bubble. A saturating counter records downstream stall cycles for performance debug.

## Interface
- `CTRL_W`, default 9: control-field width (S, B, MEM_W, MEM_R, WB_EN, EXE_CMD). Zeroed on bubble.
- `DATA_W`, default 150: payload width (operands, PC, imm, dest, shift operand, carry, src regs). Never cleared.
- `STALL_CNT_W`, default 16: width of the stall counter.
- `clk` input 1: single clock. All state updates on its rising edge.
- `rst` input 1: synchronous, active-low reset.
- `flush` input 1: squash all held entries (branch taken).
- `in_valid` input 1: upstream offers a transfer.
- `in_ready` output 1: stage can accept a transfer.
- `in_ctrl` input CTRL_W: upstream control bits.
- `in_data` input DATA_W: upstream payload.
- `out_valid` output 1: downstream entry is valid.
- `out_ready` input 1: downstream consumes this cycle.
- `out_ctrl` output CTRL_W: held control bits. Always 0 when `out_valid`=0.
- `out_data` output DATA_W: held payload.
- `stall_cnt` output STALL_CNT_W: count of cycles with `out_valid & !out_ready`.

## Operation
- in_fire = `in_valid & in_ready`. out_fire = `out_valid & out_ready`.
- Storage consists of a main register (drives outputs) and a skid register.
- State EMPTY: main and skid both empty.
  - in_fire → BUSY; main loads the input.
- State BUSY: main full, skid empty.
  - in_fire & out_fire → BUSY; main reloads from the input.
  - in_fire & !out_fire → FULL; skid loads the input.
  - !in_fire & out_fire → EMPTY.
  - Otherwise hold.
- State FULL: main and skid both full.
  - out_fire → BUSY; main loads from skid.
  - Otherwise hold.
- Output decodes:
  - `in_ready` = (state != FULL), decoded from the registered state only. No combinational path from `out_ready`.
  - `out_valid` = (state != EMPTY).
- Flush:
  - `flush`=1 forces the next state to EMPTY and clears main/skid ctrl to 0.
  - A handshake accepted in the same cycle is discarded.
  - Flush has priority over every other event except reset.
- Data fields are not cleared by flush or reset. Their value is don't-care while invalid.
- `stall_cnt` increments when `out_valid & !out_ready`.
  - Saturates at all-ones.
  - Cleared only by reset; flush does not clear it.
- Entries leave in arrival order. No reordering or duplication; each accepted transfer appears on the output exactly once unless flushed.

## Timing
- Reset (`rst`=0 at an edge):
  - state=EMPTY, `out_valid`=0, `in_ready`=1, `out_ctrl`=0, `stall_cnt`=0.
  - Reset overrides flush and all handshakes, including mid-transfer.
- Latency: a transfer accepted at edge N is presented on the outputs after edge N (one cycle) when the stage is EMPTY, or when it is BUSY with out_fire.
- Throughput is one transfer per cycle while `out_ready`=1.
- One `out_ready`=0 cycle costs no upstream bubble: the skid absorbs it. `in_ready` falls the cycle after the skid fills.
- After a FULL→BUSY drain, `in_ready` rises the following cycle.
- Flush asserted in cycle N gives `out_valid`=0 and `in_ready`=1 after edge N.

## Structure
- Shared package `pipe_pkg`:
  - state enum `{EMPTY, BUSY, FULL}`, 2 bits.
  - localparams for the default ID→EXE `CTRL_W`/`DATA_W`, plus field offsets so stages pack and unpack consistently.
- No sub-module. Main and skid registers, the state machine and the counter all live in this block.
- The ID→EXE, EXE→MEM and MEM→WB latches are each an instance with their own widths.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `in_valid`=1 → `out_valid`=0, `in_ready`=1, `out_ctrl`=0, `stall_cnt`=0.
- Streaming: `out_ready`=1, drive ctrl 0x1A5 and data values 1..8 on consecutive cycles → outputs 1..8 one cycle later, no gaps, state BUSY.
- Backpressure:
  - Stream 1,2,3 with `out_ready`=0 from the second cycle → skid holds 2, `in_ready`=0, value 3 is held upstream.
  - Release `out_ready` → output order 1,2,3, and `stall_cnt` equals the stalled cycles.
- Flush in FULL:
  - Flush while FULL with `in_valid`=1 → next cycle `out_valid`=0, `out_ctrl`=0, `in_ready`=1.
  - The flushed entries and the concurrent input never appear on the output.
- Saturation: `STALL_CNT_W`=4, `out_ready`=0 for 20 cycles with a valid entry → `stall_cnt` stops at 15; a flush leaves it at 15.
- Reset mid-stream: assert `rst`=0 while FULL with `flush`=1 → EMPTY next cycle and `stall_cnt`=0.
